// File: rtl/mio_pkg.sv
// Shared constants for the MIO bus arbiter: FSM encodings, port indices, timeout read data.
// Pure declarations; no logic, no latency, no flow control.
package mio_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not served last.
// Purely combinational (zero latency); the caller decides when a grant is taken.
module rr_arbiter2
   import mio_pkg::*;
(
   input  logic req0_vld,
   input  logic req1_vld,
   input  logic last,
   output logic gnt_vld,
   output logic gnt_idx
);

   assign gnt_vld = req0_vld | req1_vld;
   assign gnt_idx = (req0_vld & req1_vld) ? ~last : req1_vld;

endmodule

// File: rtl/mio_arbiter.sv
// Shares one memory bus between CPU and DMA: req edge -> mem_req next cycle, ready one cycle after ack/timeout.
// One access in flight; requesters are stalled by holding req until their ready pulse.
module mio_arbiter
   import mio_pkg::*;
#(
   parameter int unsigned     AW       = 32,
   parameter int unsigned     DW       = 32,
   parameter int unsigned     TIMEOUT  = 15,
   parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEF)
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,

   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ready,

   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,

   output logic          owner,
   output logic          err
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   logic [1:0]    state;
   logic [7:0]    cnt;
   logic          last;
   logic          gnt_vld;
   logic          gnt_idx;
   logic          take_gnt;
   logic          done;
   logic          timed_out;
   logic          rd_done;
   logic [DW-1:0] rsp_dat;

   rr_arbiter2 u_rr (
      .req0_vld (cpu_req),
      .req1_vld (dma_req),
      .last     (last),
      .gnt_vld  (gnt_vld),
      .gnt_idx  (gnt_idx)
   );

   // An ack in the timeout cycle still counts as a normal completion.
   assign take_gnt  = (state == ST_IDLE) && gnt_vld;
   assign done      = (state == ST_BUSY) && (mem_ack || (cnt == TO_CNT));
   assign timed_out = done && !mem_ack;
   assign rd_done   = done && !mem_we;
   assign rsp_dat   = mem_ack ? mem_rdata : ERR_DATA;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 8'd0;
         last  <= PORT_DMA;
         owner <= PORT_CPU;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  state <= ST_BUSY;
                  cnt   <= 8'd1;
                  last  <= gnt_idx;
                  owner <= gnt_idx;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  state <= ST_RESP;
                  cnt   <= 8'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (take_gnt) begin
         mem_req   <= 1'b1;
         mem_we    <= (gnt_idx == PORT_DMA) ? dma_we    : cpu_we;
         mem_addr  <= (gnt_idx == PORT_DMA) ? dma_addr  : cpu_addr;
         mem_wdata <= (gnt_idx == PORT_DMA) ? dma_wdata : cpu_wdata;
      end else if (done) begin
         mem_req <= 1'b0;
      end
   end

   // Ready and err are raised on entry to RESP, so they last exactly that one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_ready <= 1'b0;
         dma_ready <= 1'b0;
         err       <= 1'b0;
      end else begin
         cpu_ready <= done && (owner == PORT_CPU);
         dma_ready <= done && (owner == PORT_DMA);
         err       <= timed_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else if (rd_done) begin
         if (owner == PORT_DMA) begin
            dma_rdata <= rsp_dat;
         end else begin
            cpu_rdata <= rsp_dat;
         end
      end
   end

endmodule
